// File: rtl/jedro_1_decoder_pipe.sv
// Registered RV32I/RV32E instruction decoder between fetch and ALU/LSU; halts after an illegal
// instruction until flush_i. Define JEDRO_DEC_ZICSR_EN to add Zicsr decode and the csr_* ports.
module jedro_1_decoder_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      flush_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic [31:0]               instr_rdata_i,
    input  logic [DATA_WIDTH-1:0]     instr_addr_i,
    output logic                      dec_valid_o,
    input  logic                      dec_ready_i,
    output logic                      illegal_instr_o,
    output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
    output logic [1:0]                alu_src_a_o,
    output logic                      alu_src_b_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      rd_we_o,
    output logic [DATA_WIDTH-1:0]     imm_ext_o,
    output logic [DATA_WIDTH-1:0]     pc_o,
    output logic                      lsu_en_o,
    output logic [3:0]                lsu_ctrl_o,
    output logic                      branch_o,
    output logic                      jump_o,
`ifdef JEDRO_DEC_ZICSR_EN
    output logic                      csr_en_o,
    output logic [11:0]               csr_addr_o,
`endif
    output logic [1:0]                sys_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam bit RV32E = (REG_ADDR_WIDTH < 5);

    typedef struct packed {
        logic                      illegal;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [1:0]                src_a;
        logic                      src_b;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      rd_we;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     pc;
        logic                      lsu_en;
        logic [3:0]                lsu_ctrl;
        logic                      branch;
        logic                      jump;
        logic [1:0]                sys;
`ifdef JEDRO_DEC_ZICSR_EN
        logic                      csr_en;
        logic [11:0]               csr_addr;
`endif
    } pkt_t;

    logic [31:0]        instr;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic               legal, writes, use_rd, use_rs1, use_rs2;
    pkt_t               dec;

    logic [0:0] state_q, state_d;
    logic       dec_valid_q, dec_valid_d;
    pkt_t       pkt_q, pkt_d;
    logic       capture;

    assign instr  = instr_rdata_i;
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.rs1      = instr[15 +: REG_ADDR_WIDTH];
        dec.rs2      = instr[20 +: REG_ADDR_WIDTH];
        dec.rd       = instr[7 +: REG_ADDR_WIDTH];
        dec.imm      = DATA_WIDTH'(imm_i);
        dec.pc       = instr_addr_i;
`ifdef JEDRO_DEC_ZICSR_EN
        dec.csr_addr = instr[31:20];
`endif
        legal   = 1'b1;
        writes  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec.alu_op[3:0] = {instr[30], funct3};
                writes = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) legal = (funct7 == 7'h00);
                if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                dec.alu_op[3:0] = {(funct3 == 3'b101) & instr[30], funct3};
                dec.src_b = 1'b1;
                writes = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec.src_b    = 1'b1;
                dec.lsu_en   = 1'b1;
                dec.lsu_ctrl = {1'b0, funct3};
                writes = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
                dec.src_b    = 1'b1;
                dec.imm      = DATA_WIDTH'(imm_s);
                dec.lsu_en   = 1'b1;
                dec.lsu_ctrl = {1'b1, funct3};
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.src_a = (instr[5]) ? 2'b10 : 2'b01;
                dec.src_b = 1'b1;
                dec.imm   = DATA_WIDTH'(imm_u);
                writes = 1'b1; use_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.src_a = 2'b01;
                dec.src_b = 1'b1;
                dec.imm   = DATA_WIDTH'(imm_j);
                dec.jump  = 1'b1;
                writes = 1'b1; use_rd = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                dec.src_b = 1'b1;
                dec.jump  = 1'b1;
                writes = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3[2:1] != 2'b01);
                dec.alu_op[3:0] = {1'b0, funct3};
                dec.imm    = DATA_WIDTH'(imm_b);
                dec.branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_MISC: ;
            OPC_SYSTEM: begin
                if (funct3 == 3'b000 && instr[31:20] == 12'h000) begin
                    dec.sys = 2'b01;
                end else if (funct3 == 3'b000 && instr[31:20] == 12'h001) begin
                    dec.sys = 2'b10;
`ifdef JEDRO_DEC_ZICSR_EN
                end else if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    // funct3[2] selects the zimm forms, where rs1 field is an operand, not a register
                    dec.csr_en = 1'b1;
                    writes  = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = ~funct3[2];
                    if (funct3[2]) dec.imm = DATA_WIDTH'(instr[19:15]);
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (RV32E && ((use_rd && instr[11]) || (use_rs1 && instr[19]) || (use_rs2 && instr[24])))
            legal = 1'b0;
        dec.illegal = ~legal;
        dec.rd_we   = legal & writes & (instr[11:7] != 5'd0);
        if (!legal) begin
            dec.lsu_en = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
            dec.sys    = 2'b00;
`ifdef JEDRO_DEC_ZICSR_EN
            dec.csr_en = 1'b0;
`endif
        end
    end

    assign instr_ready_o = rstn_i & (state_q == ST_RUN) & ~flush_i & (~dec_valid_q | dec_ready_i);
    assign capture       = instr_valid_i & instr_ready_o;

    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        pkt_d       = pkt_q;
        if (flush_i) begin
            dec_valid_d = 1'b0;
            state_d     = ST_RUN;
        end else if (capture) begin
            pkt_d       = dec;
            dec_valid_d = 1'b1;
            state_d     = dec.illegal ? ST_HALT : ST_RUN;
        end else if (dec_ready_i) begin
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_RUN;
            dec_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dec_valid_q <= dec_valid_d;
            pkt_q       <= pkt_d;
        end
    end

    assign dec_valid_o     = dec_valid_q;
    assign illegal_instr_o = pkt_q.illegal;
    assign alu_op_sel_o    = pkt_q.alu_op;
    assign alu_src_a_o     = pkt_q.src_a;
    assign alu_src_b_o     = pkt_q.src_b;
    assign rs1_addr_o      = pkt_q.rs1;
    assign rs2_addr_o      = pkt_q.rs2;
    assign rd_addr_o       = pkt_q.rd;
    assign rd_we_o         = pkt_q.rd_we;
    assign imm_ext_o       = pkt_q.imm;
    assign pc_o            = pkt_q.pc;
    assign lsu_en_o        = pkt_q.lsu_en;
    assign lsu_ctrl_o      = pkt_q.lsu_ctrl;
    assign branch_o        = pkt_q.branch;
    assign jump_o          = pkt_q.jump;
    assign sys_o           = pkt_q.sys;
`ifdef JEDRO_DEC_ZICSR_EN
    assign csr_en_o        = pkt_q.csr_en;
    assign csr_addr_o      = pkt_q.csr_addr;
`endif

endmodule

// File: tb/tb_jedro_1_decoder_pipe.sv
// Bench for jedro_1_decoder_pipe: directed steps then randomized traffic against a reference
// decoder and handshake model.
module tb_jedro_1_decoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, flush, ivalid, dready;
    logic [31:0] instr, pc;
    logic        iready, dvalid, ill, sb, we, lsu, br, jmp;
    logic [3:0]  aop, lctl;
    logic [1:0]  sa, sys;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pco;
`ifdef JEDRO_DEC_ZICSR_EN
    logic        csr_en, e_csr_en;
    logic [11:0] csr_addr, e_csr_addr;
`endif

    // RV32E instance, only driven by the small-register-file step
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_iready, e_dvalid, e_ill, e_sb, e_we, e_lsu, e_br, e_jmp;
    logic [3:0]  e_aop, e_lctl;
    logic [1:0]  e_sa, e_sys;
    logic [3:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm, e_pco;

    jedro_1_decoder_pipe dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .instr_valid_i(ivalid), .instr_ready_o(iready),
        .instr_rdata_i(instr), .instr_addr_i(pc),
        .dec_valid_o(dvalid), .dec_ready_i(dready),
        .illegal_instr_o(ill), .alu_op_sel_o(aop), .alu_src_a_o(sa), .alu_src_b_o(sb),
        .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd), .rd_we_o(we),
        .imm_ext_o(imm), .pc_o(pco), .lsu_en_o(lsu), .lsu_ctrl_o(lctl),
        .branch_o(br), .jump_o(jmp),
`ifdef JEDRO_DEC_ZICSR_EN
        .csr_en_o(csr_en), .csr_addr_o(csr_addr),
`endif
        .sys_o(sys)
    );

    jedro_1_decoder_pipe #(.REG_ADDR_WIDTH(4)) dut_e (
        .clk_i(clk), .rstn_i(rstn), .flush_i(1'b0),
        .instr_valid_i(e_valid), .instr_ready_o(e_iready),
        .instr_rdata_i(e_instr), .instr_addr_i(32'h0),
        .dec_valid_o(e_dvalid), .dec_ready_i(1'b1),
        .illegal_instr_o(e_ill), .alu_op_sel_o(e_aop), .alu_src_a_o(e_sa), .alu_src_b_o(e_sb),
        .rs1_addr_o(e_rs1), .rs2_addr_o(e_rs2), .rd_addr_o(e_rd), .rd_we_o(e_we),
        .imm_ext_o(e_imm), .pc_o(e_pco), .lsu_en_o(e_lsu), .lsu_ctrl_o(e_lctl),
        .branch_o(e_br), .jump_o(e_jmp),
`ifdef JEDRO_DEC_ZICSR_EN
        .csr_en_o(e_csr_en), .csr_addr_o(e_csr_addr),
`endif
        .sys_o(e_sys)
    );

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [1:0]  sa;
        logic        sb;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] imm, pc;
        logic        lsu;
        logic [3:0]  lctl;
        logic        br, jmp;
        logic [1:0]  sys;
        logic        csr_en;
        logic [11:0] csr_addr;
    } ref_t;

    int   checks = 0;
    int   failures = 0;
    logic m_valid, m_run;
    ref_t m_pkt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder written straight from the instruction-set rules
    function automatic ref_t ref_dec(input logic [31:0] w, input logic [31:0] a);
        ref_t p;
        logic ok, wr;
        logic [2:0] f3;
        logic [6:0] f7;
        int i_imm, s_imm, b_imm, j_imm;
        f3 = w[14:12];
        f7 = w[31:25];
        i_imm = $signed(w[31:20]);
        s_imm = $signed({w[31:25], w[11:7]});
        b_imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        j_imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        p = '0;
        p.pc = a; p.rs1 = w[19:15]; p.rs2 = w[24:20]; p.rd = w[11:7];
        p.imm = i_imm; p.csr_addr = w[31:20];
        ok = 1'b1; wr = 1'b0;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
                p.op = {w[30], f3}; wr = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = f7 inside {7'h00, 7'h20};
                p.op = {(f3 == 3'd5) ? w[30] : 1'b0, f3}; p.sb = 1'b1; wr = 1'b1;
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                p.sb = 1'b1; p.lsu = 1'b1; p.lctl = {1'b0, f3}; wr = 1'b1;
            end
            7'h23: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2};
                p.sb = 1'b1; p.imm = s_imm; p.lsu = 1'b1; p.lctl = {1'b1, f3};
            end
            7'h37: begin p.sa = 2'd2; p.sb = 1'b1; p.imm = {w[31:12], 12'h0}; wr = 1'b1; end
            7'h17: begin p.sa = 2'd1; p.sb = 1'b1; p.imm = {w[31:12], 12'h0}; wr = 1'b1; end
            7'h6F: begin p.sa = 2'd1; p.sb = 1'b1; p.imm = j_imm; p.jmp = 1'b1; wr = 1'b1; end
            7'h67: begin ok = (f3 == 3'd0); p.sb = 1'b1; p.jmp = 1'b1; wr = 1'b1; end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3});
                p.op = {1'b0, f3}; p.imm = b_imm; p.br = 1'b1;
            end
            7'h0F: ;
            7'h73: begin
                if (f3 == 3'd0 && w[31:20] == 12'd0) p.sys = 2'b01;
                else if (f3 == 3'd0 && w[31:20] == 12'd1) p.sys = 2'b10;
`ifdef JEDRO_DEC_ZICSR_EN
                else if (!(f3 inside {3'd0, 3'd4})) begin
                    p.csr_en = 1'b1; wr = 1'b1;
                    if (f3 >= 3'd5) p.imm = {27'd0, w[19:15]};
                end
`endif
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        p.ill = !ok;
        p.we  = ok && wr && (w[11:7] != 5'd0);
        if (!ok) begin p.lsu = 0; p.br = 0; p.jmp = 0; p.sys = 0; p.csr_en = 0; end
        return p;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        logic [6:0]  opc [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
                                  7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73};
        int k;
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = opc[k];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            w[31:20] = 12'($urandom_range(0, 1));
            w[14:12] = 3'd0;
        end
        return w;
    endfunction

    task automatic chk_pkt();
        chk("illegal", {63'd0, ill}, {63'd0, m_pkt.ill});
        chk("rd_we", {63'd0, we}, {63'd0, m_pkt.we});
        chk("lsu_en", {63'd0, lsu}, {63'd0, m_pkt.lsu});
        chk("branch", {63'd0, br}, {63'd0, m_pkt.br});
        chk("jump", {63'd0, jmp}, {63'd0, m_pkt.jmp});
        chk("sys", {62'd0, sys}, {62'd0, m_pkt.sys});
        chk("pc", {32'd0, pco}, {32'd0, m_pkt.pc});
        if (!m_pkt.ill) begin
            chk("alu_op", {60'd0, aop}, {60'd0, m_pkt.op});
            chk("src_a", {62'd0, sa}, {62'd0, m_pkt.sa});
            chk("src_b", {63'd0, sb}, {63'd0, m_pkt.sb});
            chk("rs1", {59'd0, rs1}, {59'd0, m_pkt.rs1});
            chk("rs2", {59'd0, rs2}, {59'd0, m_pkt.rs2});
            chk("rd", {59'd0, rd}, {59'd0, m_pkt.rd});
            chk("imm", {32'd0, imm}, {32'd0, m_pkt.imm});
            chk("lsu_ctrl", {60'd0, lctl}, {60'd0, m_pkt.lctl});
`ifdef JEDRO_DEC_ZICSR_EN
            chk("csr_en", {63'd0, csr_en}, {63'd0, m_pkt.csr_en});
            chk("csr_addr", {52'd0, csr_addr}, {52'd0, m_pkt.csr_addr});
`endif
        end
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge
    task automatic tick();
        logic exp_rdy;
        #1;
        exp_rdy = rstn && m_run && !flush && (!m_valid || dready);
        chk("instr_ready", {63'd0, iready}, {63'd0, exp_rdy});
        chk("dec_valid", {63'd0, dvalid}, {63'd0, m_valid});
        if (m_valid) chk_pkt();
        if (!rstn) begin
            m_valid = 0; m_run = 1; m_pkt = '0;
        end else if (flush) begin
            m_valid = 0; m_run = 1;
        end else if (ivalid && exp_rdy) begin
            m_pkt = ref_dec(instr, pc); m_valid = 1; m_run = !m_pkt.ill;
        end else if (m_valid && dready) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 0; flush = 0; ivalid = 0; dready = 1; instr = 0; pc = 0;
        e_valid = 0; e_instr = 0;
        m_valid = 0; m_run = 1; m_pkt = '0;
        @(posedge clk); #1;
        chk("rst_ready", {63'd0, iready}, 64'd0);
        tick(); tick();
        chk("rst_valid", {63'd0, dvalid}, 64'd0);
        chk("rst_illegal", {63'd0, ill}, 64'd0);
        chk("rst_imm", {32'd0, imm}, 64'd0);
        chk("rst_pc", {32'd0, pco}, 64'd0);
        chk("rst_alu_op", {60'd0, aop}, 64'd0);
        rstn = 1;

        ivalid = 1; instr = 32'h002081B3; pc = 32'h100; tick();
        chk("add_op", {60'd0, aop}, 64'h0);
        chk("add_rs1", {59'd0, rs1}, 64'd1);
        chk("add_rs2", {59'd0, rs2}, 64'd2);
        chk("add_rd", {59'd0, rd}, 64'd3);
        instr = 32'h402081B3; pc = 32'h104; tick();
        chk("sub_valid", {63'd0, dvalid}, 64'd1);
        chk("sub_op", {60'd0, aop}, 64'h8);
        instr = 32'hFFC12283; pc = 32'h108; tick();
        chk("lw_imm", {32'd0, imm}, 64'hFFFFFFFC);
        chk("lw_lsu_ctrl", {60'd0, lctl}, 64'h2);
        chk("lw_lsu_en", {63'd0, lsu}, 64'd1);
        chk("lw_rd_we", {63'd0, we}, 64'd1);
        instr = 32'h801FF0EF; pc = 32'h10C; tick();
        chk("jal_imm", {32'd0, imm}, 64'hFFFFF800);
        chk("jal_jump", {63'd0, jmp}, 64'd1);
        chk("jal_src_a", {62'd0, sa}, 64'd1);
        // B-format fields of this word give offset -4
        instr = 32'hFE000EE3; pc = 32'h110; tick();
        chk("beq_imm", {32'd0, imm}, 64'hFFFFFFFC);
        chk("beq_branch", {63'd0, br}, 64'd1);

        dready = 0; instr = 32'h00500093; pc = 32'h200;
        repeat (3) begin
            tick();
            chk("stall_ready", {63'd0, iready}, 64'd0);
            chk("stall_pc", {32'd0, pco}, 64'h110);
        end
        dready = 1; tick();
        chk("release_pc", {32'd0, pco}, 64'h200);

        instr = 32'h0; pc = 32'h300; tick();
        chk("zero_illegal", {63'd0, ill}, 64'd1);
        instr = 32'h00500093; pc = 32'h304; tick();
        chk("halt_ready", {63'd0, iready}, 64'd0);
        chk("halt_valid", {63'd0, dvalid}, 64'd0);
        flush = 1; tick();
        flush = 0; ivalid = 0; #1;
        chk("flush_valid", {63'd0, dvalid}, 64'd0);
        chk("flush_ready", {63'd0, iready}, 64'd1);
        tick();

        ivalid = 1; instr = 32'h30029073; pc = 32'h400; tick();
`ifdef JEDRO_DEC_ZICSR_EN
        chk("csrrw_illegal", {63'd0, ill}, 64'd0);
        chk("csrrw_en", {63'd0, csr_en}, 64'd1);
        chk("csrrw_addr", {52'd0, csr_addr}, 64'h300);
`else
        chk("csrrw_illegal", {63'd0, ill}, 64'd1);
`endif
        ivalid = 0; flush = 1; tick();
        flush = 0;

        e_valid = 1; e_instr = 32'h00100793; tick();
        chk("rv32e_x15_illegal", {63'd0, e_ill}, 64'd0);
        e_instr = 32'h00100813; tick();
        chk("rv32e_x16_illegal", {63'd0, e_ill}, 64'd1);
        e_valid = 0;

        ivalid = 1; dready = 0; instr = 32'h00A00113; pc = 32'h500; tick();
        tick();
        rstn = 0; tick();
        chk("rst_stall_valid", {63'd0, dvalid}, 64'd0);
        rstn = 1;

        repeat (3000) begin
            ivalid = ($urandom_range(0, 3) != 0);
            dready = ($urandom_range(0, 3) != 0);
            flush  = (!m_run && $urandom_range(0, 2) == 0) || ($urandom_range(0, 40) == 0);
            instr  = gen();
            pc     = $urandom();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
